// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared sizing constants for the MEM-stage data memory
package data_memory_pkg;
    localparam int DATA_WIDTH       = 32;
    localparam int DMEM_DEPTH       = 256;
    localparam int DMEM_INDEX_WIDTH = $clog2(DMEM_DEPTH);
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, synchronous write, combinational read, synchronous clear
module data_memory #(
    parameter int DATA_WIDTH  = data_memory_pkg::DATA_WIDTH,
    parameter int DEPTH       = data_memory_pkg::DMEM_DEPTH,
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Mem_Write,
    input  logic                  Mem_Read,
    output logic [DATA_WIDTH-1:0] Read_Data
);
    logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];
    logic [INDEX_WIDTH-1:0] idx;
    logic                   unused_addr;
    assign idx         = Address[INDEX_WIDTH-1:0];
    // high address bits are ignored so indexing wraps modulo DEPTH
    assign unused_addr = ^Address[31:INDEX_WIDTH];
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (Mem_Write) begin
            mem[idx] <= Write_Data;
        end
    end
    assign Read_Data = Mem_Read ? mem[idx] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: vector table, hand sequence and randomized model check for data_memory
module tb_data_memory;
    logic        Clk = 0;
    logic        Reset_n = 0;
    logic [31:0] Address = '0;
    logic [31:0] Write_Data = '0;
    logic        Mem_Write = 0;
    logic        Mem_Read = 0;
    logic [31:0] Read_Data;
    int checks = 0;
    int errors = 0;

    data_memory dut (
        .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .Write_Data(Write_Data),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Read_Data(Read_Data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) assert (!$isunknown(Mem_Write)) else $error("Mem_Write is X/Z");

    typedef struct {
        logic        rst_n;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [21];
    logic [31:0] model [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge Clk);
        Reset_n = rst_n; Mem_Write = we; Mem_Read = re; Address = addr; Write_Data = wdata;
        #1;
    endtask

    initial begin
        vecs = '{
            '{0, 0, 0, 32'd0,   32'd0,          32'd0},
            '{0, 0, 0, 32'd0,   32'd0,          32'd0},
            '{1, 0, 1, 32'd0,   32'd0,          32'd0},
            '{1, 0, 1, 32'd3,   32'd0,          32'd0},
            '{1, 0, 1, 32'd255, 32'd0,          32'd0},
            '{1, 1, 0, 32'd3,   32'd150,        32'd0},
            '{1, 0, 1, 32'd3,   32'd0,          32'd150},
            '{1, 0, 0, 32'd3,   32'd0,          32'd0},
            '{1, 1, 0, 32'd5,   32'hAAAA_AAAA,  32'd0},
            '{1, 1, 1, 32'd5,   32'h5555_5555,  32'hAAAA_AAAA},
            '{1, 0, 1, 32'd5,   32'd0,          32'h5555_5555},
            '{1, 1, 0, 32'd259, 32'h1234_5678,  32'd0},
            '{1, 0, 1, 32'd3,   32'd0,          32'h1234_5678},
            '{0, 1, 1, 32'd7,   32'd99,         32'd0},
            '{1, 0, 1, 32'd7,   32'd0,          32'd0},
            '{1, 0, 1, 32'd3,   32'd0,          32'd0},
            '{1, 1, 0, 32'd0,   32'd10,         32'd0},
            '{1, 1, 0, 32'd255, 32'd20,         32'd0},
            '{1, 0, 1, 32'd0,   32'd0,          32'd10},
            '{1, 0, 1, 32'd255, 32'd0,          32'd20},
            '{1, 0, 1, 32'd1,   32'd0,          32'd0}
        };
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d", i), Read_Data, vecs[i].exp);
        end

        // read-during-write: old word before the edge, new word just after it
        drive(1, 1, 1, 32'd9, 32'hDEAD_BEEF);
        check("rdw_pre", Read_Data, 32'd0);
        @(posedge Clk); #1;
        check("rdw_post", Read_Data, 32'hDEAD_BEEF);
        drive(1, 0, 1, 32'd265, 32'd0);
        check("rdw_alias", Read_Data, 32'hDEAD_BEEF);

        // randomized phase starts from a fresh reset so the model is exactly known
        drive(0, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic        rst_n, we, re;
            logic [31:0] addr, wdata;
            int          k;
            rst_n = ($urandom_range(0, 39) != 0);
            we    = $urandom_range(0, 1) == 1;
            re    = $urandom_range(0, 3) != 0;
            addr  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) * 17 % 256);
            wdata = $urandom();
            drive(rst_n, we, re, addr, wdata);
            k = int'(addr % 256);
            check("rand_read", Read_Data, re ? model[k] : 32'd0);
            if (!rst_n) for (int i = 0; i < 256; i++) model[i] = 32'd0;
            else if (we) model[k] = wdata;
        end
        drive(1, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 256; i += 51) begin
            drive(1, 0, 1, 32'(i), 32'd0);
            check("final_sweep", Read_Data, model[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
